// File: rtl/dest_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// dest_pipeline_ctrl
//
// Producer side of the operand-forwarding interface. Carries the destination
// register index, write enable and result data of each instruction through the
// EX/MEM and MEM/WB pipeline registers, so the forwarding unit can compare them
// against the operands of younger instructions. Also detects load-use hazards,
// which forwarding cannot cover, and requests a one-cycle stall plus bubble.
//
// Optional feature (compile-time macro STALL_COUNT_EN):
//   adds stall_cnt_o, a saturating 32-bit count of cycles with a load-use hazard.
//   With the macro undefined the port and the counter do not exist.
//
// Parameters:
//   DATA_W  width of ALU result, memory read data and write-back data
//   REG_AW  register-index width
//
// Ports:
//   clk_i             clock, all state updates on the rising edge
//   rst_i             synchronous active-high reset
//   flush_i           squash the instruction entering EX/MEM this cycle
//   IFID_rs1_i        rs1 of the instruction in ID
//   IFID_rs2_i        rs2 of the instruction in ID
//   IDEX_rd_i         rd of the instruction in EX
//   IDEX_RegWrite_i   EX instruction writes rd
//   IDEX_MemRead_i    EX instruction is a load
//   IDEX_MemtoReg_i   write-back selects memory data
//   ALU_result_i      EX-stage ALU output
//   MEM_rdata_i       data-memory read data, valid during the MEM stage
//   EXMEM_ALUres_o    registered ALU result (EX-hazard forward value)
//   EXMEM_rd_o        EX/MEM destination register
//   EXMEM_RegWrite_o  EX/MEM write enable
//   EXMEM_MemRead_o   EX/MEM load flag, to data memory
//   MEMWB_rd_o        MEM/WB destination register
//   MEMWB_RegWrite_o  MEM/WB write enable
//   WB_data_o         write-back data (MEM-hazard forward value)
//   Stall_o           hold IF/ID
//   PCWrite_o         PC update enable
//   NoOp_o            zero the ID/EX control fields next cycle
//   stall_cnt_o       (STALL_COUNT_EN only) saturating hazard-cycle count
// -----------------------------------------------------------------------------
module dest_pipeline_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] IFID_rs1_i,
  input  logic [REG_AW-1:0] IFID_rs2_i,
  input  logic [REG_AW-1:0] IDEX_rd_i,
  input  logic              IDEX_RegWrite_i,
  input  logic              IDEX_MemRead_i,
  input  logic              IDEX_MemtoReg_i,
  input  logic [DATA_W-1:0] ALU_result_i,
  input  logic [DATA_W-1:0] MEM_rdata_i,
  output logic [DATA_W-1:0] EXMEM_ALUres_o,
  output logic [REG_AW-1:0] EXMEM_rd_o,
  output logic              EXMEM_RegWrite_o,
  output logic              EXMEM_MemRead_o,
  output logic [REG_AW-1:0] MEMWB_rd_o,
  output logic              MEMWB_RegWrite_o,
  output logic [DATA_W-1:0] WB_data_o,
  output logic              Stall_o,
  output logic              PCWrite_o,
`ifdef STALL_COUNT_EN
  output logic              NoOp_o,
  output logic [31:0]       stall_cnt_o
`else
  output logic              NoOp_o
`endif
);

  // ---------------------------------------------------------------------------
  // EX/MEM stage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] exmem_alures_q, exmem_alures_d;
  logic [REG_AW-1:0] exmem_rd_q, exmem_rd_d;
  logic              exmem_regwrite_q, exmem_regwrite_d;
  logic              exmem_memread_q, exmem_memread_d;
  logic              exmem_memtoreg_q, exmem_memtoreg_d;

  logic              idex_rd_nonzero;

  assign idex_rd_nonzero = (IDEX_rd_i != '0);

  always_comb begin
    exmem_alures_d   = ALU_result_i;
    exmem_rd_d       = IDEX_rd_i;
    exmem_memtoreg_d = IDEX_MemtoReg_i;
    // Writes to x0 are dropped here so the forwarding unit never sees them.
    exmem_regwrite_d = IDEX_RegWrite_i & idex_rd_nonzero;
    exmem_memread_d  = IDEX_MemRead_i;
    // A flushed instruction keeps its rd/data (don't-care) but loses its side effects.
    if (flush_i) begin
      exmem_regwrite_d = 1'b0;
      exmem_memread_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exmem_alures_q   <= '0;
      exmem_rd_q       <= '0;
      exmem_regwrite_q <= 1'b0;
      exmem_memread_q  <= 1'b0;
      exmem_memtoreg_q <= 1'b0;
    end else begin
      exmem_alures_q   <= exmem_alures_d;
      exmem_rd_q       <= exmem_rd_d;
      exmem_regwrite_q <= exmem_regwrite_d;
      exmem_memread_q  <= exmem_memread_d;
      exmem_memtoreg_q <= exmem_memtoreg_d;
    end
  end

  assign EXMEM_ALUres_o   = exmem_alures_q;
  assign EXMEM_rd_o       = exmem_rd_q;
  assign EXMEM_RegWrite_o = exmem_regwrite_q;
  assign EXMEM_MemRead_o  = exmem_memread_q;

  // ---------------------------------------------------------------------------
  // MEM/WB stage
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0] memwb_rd_q;
  logic              memwb_regwrite_q;
  logic              memwb_memtoreg_q;
  logic [DATA_W-1:0] memwb_alures_q;
  logic [DATA_W-1:0] memwb_rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      memwb_rd_q       <= '0;
      memwb_regwrite_q <= 1'b0;
      memwb_memtoreg_q <= 1'b0;
      memwb_alures_q   <= '0;
      memwb_rdata_q    <= '0;
    end else begin
      memwb_rd_q       <= exmem_rd_q;
      memwb_regwrite_q <= exmem_regwrite_q;
      memwb_memtoreg_q <= exmem_memtoreg_q;
      memwb_alures_q   <= exmem_alures_q;
      // Memory data belongs to the instruction currently in MEM.
      memwb_rdata_q    <= MEM_rdata_i;
    end
  end

  assign MEMWB_rd_o       = memwb_rd_q;
  assign MEMWB_RegWrite_o = memwb_regwrite_q;
  assign WB_data_o        = memwb_memtoreg_q ? memwb_rdata_q : memwb_alures_q;

  // ---------------------------------------------------------------------------
  // Load-use hazard detection
  // ---------------------------------------------------------------------------
  // Purely combinational: the bubble it inserts clears IDEX_MemRead_i on the
  // next cycle, so each load-use pair costs exactly one stall cycle.
  logic haz;

  assign haz = IDEX_MemRead_i & idex_rd_nonzero &
               ((IDEX_rd_i == IFID_rs1_i) | (IDEX_rd_i == IFID_rs2_i)) & ~rst_i;

  assign Stall_o   = haz;
  assign NoOp_o    = haz;
  assign PCWrite_o = ~haz;

`ifdef STALL_COUNT_EN
  // ---------------------------------------------------------------------------
  // Saturating hazard-cycle counter
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (haz && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dest_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dest_pipeline_ctrl
//
// Directed self-checking bench for dest_pipeline_ctrl. Inputs change 1 ns after
// the rising edge; registered outputs are sampled 1 ns after the edge and
// combinational outputs 1 ns after their inputs settle.
// -----------------------------------------------------------------------------
module tb_dest_pipeline_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [REG_AW-1:0] ifid_rs1;
  logic [REG_AW-1:0] ifid_rs2;
  logic [REG_AW-1:0] idex_rd;
  logic              idex_regwrite;
  logic              idex_memread;
  logic              idex_memtoreg;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] exmem_alures;
  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_regwrite;
  logic              exmem_memread;
  logic [REG_AW-1:0] memwb_rd;
  logic              memwb_regwrite;
  logic [DATA_W-1:0] wb_data;
  logic              stall;
  logic              pcwrite;
  logic              noop;
`ifdef STALL_COUNT_EN
  logic [31:0]       stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dest_pipeline_ctrl #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .IFID_rs1_i      (ifid_rs1),
    .IFID_rs2_i      (ifid_rs2),
    .IDEX_rd_i       (idex_rd),
    .IDEX_RegWrite_i (idex_regwrite),
    .IDEX_MemRead_i  (idex_memread),
    .IDEX_MemtoReg_i (idex_memtoreg),
    .ALU_result_i    (alu_result),
    .MEM_rdata_i     (mem_rdata),
    .EXMEM_ALUres_o  (exmem_alures),
    .EXMEM_rd_o      (exmem_rd),
    .EXMEM_RegWrite_o(exmem_regwrite),
    .EXMEM_MemRead_o (exmem_memread),
    .MEMWB_rd_o      (memwb_rd),
    .MEMWB_RegWrite_o(memwb_regwrite),
    .WB_data_o       (wb_data),
    .Stall_o         (stall),
    .PCWrite_o       (pcwrite),
`ifdef STALL_COUNT_EN
    .NoOp_o          (noop),
    .stall_cnt_o     (stall_cnt)
`else
    .NoOp_o          (noop)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idex_clear();
    idex_rd       = '0;
    idex_regwrite = 1'b0;
    idex_memread  = 1'b0;
    idex_memtoreg = 1'b0;
    alu_result    = '0;
  endtask

  task automatic idex_set(input logic [REG_AW-1:0] rd, input logic rw, input logic mr,
                          input logic m2r, input logic [DATA_W-1:0] alu);
    idex_rd       = rd;
    idex_regwrite = rw;
    idex_memread  = mr;
    idex_memtoreg = m2r;
    alu_result    = alu;
  endtask

  task automatic check_haz(input string tag, input logic exp_haz);
    #1;
    check_eq({tag, "_stall"},   32'(stall),   32'(exp_haz));
    check_eq({tag, "_noop"},    32'(noop),    32'(exp_haz));
    check_eq({tag, "_pcwrite"}, 32'(pcwrite), 32'(!exp_haz));
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    ifid_rs1  = '0;
    ifid_rs2  = '0;
    mem_rdata = '0;
    idex_clear();

    // Reset, with a would-be hazard presented to prove it is masked.
    idex_set(5'd7, 1'b1, 1'b1, 1'b1, 32'hAAAA_5555);
    ifid_rs1 = 5'd7;
    tick();
    tick();
    check_eq("rst_exmem_rd",    32'(exmem_rd),       32'd0);
    check_eq("rst_exmem_rw",    32'(exmem_regwrite), 32'd0);
    check_eq("rst_exmem_mr",    32'(exmem_memread),  32'd0);
    check_eq("rst_exmem_alu",   exmem_alures,        32'd0);
    check_eq("rst_memwb_rd",    32'(memwb_rd),       32'd0);
    check_eq("rst_memwb_rw",    32'(memwb_regwrite), 32'd0);
    check_eq("rst_wb_data",     wb_data,             32'd0);
    check_haz("rst_haz_masked", 1'b0);

    rst = 1'b0;
    idex_clear();
    ifid_rs1 = '0;

    // Plain ALU write to x5 through both stages.
    idex_set(5'd5, 1'b1, 1'b0, 1'b0, 32'h0000_1234);
    tick();
    check_eq("alu_exmem_rd",  32'(exmem_rd),       32'd5);
    check_eq("alu_exmem_rw",  32'(exmem_regwrite), 32'd1);
    check_eq("alu_exmem_alu", exmem_alures,        32'h0000_1234);
    idex_clear();
    tick();
    check_eq("alu_memwb_rd",  32'(memwb_rd),       32'd5);
    check_eq("alu_memwb_rw",  32'(memwb_regwrite), 32'd1);
    check_eq("alu_wb_data",   wb_data,             32'h0000_1234);
    check_eq("alu_exmem_idle_rw", 32'(exmem_regwrite), 32'd0);

    // Load-use on rs2, then the bubble clears it.
    idex_set(5'd7, 1'b1, 1'b1, 1'b1, 32'h0);
    ifid_rs1 = 5'd1;
    ifid_rs2 = 5'd7;
    check_haz("lu_rs2", 1'b1);
    tick();
    check_eq("lu_exmem_mr", 32'(exmem_memread), 32'd1);
    idex_clear();
    check_haz("lu_bubble", 1'b0);

    // Load-use on rs1, no match, and a matching non-load.
    idex_set(5'd9, 1'b1, 1'b1, 1'b1, 32'h0);
    ifid_rs1 = 5'd9;
    ifid_rs2 = 5'd0;
    check_haz("lu_rs1", 1'b1);
    ifid_rs1 = 5'd8;
    ifid_rs2 = 5'd10;
    check_haz("lu_nomatch", 1'b0);
    idex_set(5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
    check_haz("nonload_match", 1'b0);

    // x0: writes dropped, loads into x0 never stall.
    idex_set(5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0042);
    tick();
    check_eq("x0_exmem_rw", 32'(exmem_regwrite), 32'd0);
    idex_set(5'd0, 1'b1, 1'b1, 1'b1, 32'h0);
    ifid_rs1 = 5'd0;
    ifid_rs2 = 5'd0;
    check_haz("x0_load", 1'b0);

    // Flush squashes RegWrite/MemRead in EX/MEM, and the squash reaches MEM/WB.
    idex_set(5'd4, 1'b1, 1'b1, 1'b0, 32'h0000_0004);
    flush = 1'b1;
    tick();
    check_eq("flush_exmem_rw", 32'(exmem_regwrite), 32'd0);
    check_eq("flush_exmem_mr", 32'(exmem_memread),  32'd0);
    flush = 1'b0;
    idex_clear();
    tick();
    check_eq("flush_memwb_rw", 32'(memwb_regwrite), 32'd0);

    // Flush during a stall: hazard still reported, EX/MEM still squashed.
    idex_set(5'd6, 1'b1, 1'b1, 1'b1, 32'h0);
    ifid_rs1 = 5'd6;
    flush = 1'b1;
    check_haz("flush_stall", 1'b1);
    tick();
    check_eq("flush_stall_exmem_mr", 32'(exmem_memread),  32'd0);
    check_eq("flush_stall_exmem_rw", 32'(exmem_regwrite), 32'd0);
    flush = 1'b0;
    ifid_rs1 = 5'd0;

    // Load to x3, memory data returned in MEM, selected at WB.
    idex_set(5'd3, 1'b1, 1'b1, 1'b1, 32'h0000_0055);
    tick();
    idex_clear();
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rdata = '0;
    check_eq("ld_memwb_rd", 32'(memwb_rd),       32'd3);
    check_eq("ld_memwb_rw", 32'(memwb_regwrite), 32'd1);
    check_eq("ld_wb_data",  wb_data,             32'hDEAD_BEEF);

    // Mid-run reset clears a populated MEM/WB stage.
    rst = 1'b1;
    tick();
    check_eq("rst2_memwb_rw", 32'(memwb_regwrite), 32'd0);
    check_eq("rst2_wb_data",  wb_data,             32'd0);
`ifdef STALL_COUNT_EN
    check_eq("cnt_rst", stall_cnt, 32'd0);
`endif
    rst = 1'b0;

`ifdef STALL_COUNT_EN
    // Three consecutive hazard cycles.
    idex_set(5'd2, 1'b1, 1'b1, 1'b1, 32'h0);
    ifid_rs2 = 5'd2;
    tick();
    tick();
    tick();
    idex_clear();
    ifid_rs2 = 5'd0;
    tick();
    check_eq("cnt_three", stall_cnt, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
